pid_math_mc: RTL and testbench

//  Multi-channel successor to the single-axis PD math block. It takes (desired, actual)

---
 rtl/pid_math_mc.sv | 183 ++++++++++++++++++
 tb/tb_pid_math_mc.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pid_math_mc.sv
// Multi-channel PID term datapath: one shared 2-stage pipeline, with a per-channel error history and integrator.
// States: IDLE = accepting samples | CLR = zeroing one channel per cycle, in_rdy low.
module pid_math_mc #(
  parameter int NCH     = 3,
  parameter int CHW     = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int IN_W    = 16,
  parameter int ERR_W   = 10,
  parameter int D_DEPTH = 12,
  parameter int DD_W    = 7,
  parameter logic signed [4:0] D_COEFF = 5'sd7,
  parameter int I_W     = 16,
  parameter int I_SHIFT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [CHW-1:0]           in_ch,
  input  logic [IN_W-1:0]          desired,
  input  logic [IN_W-1:0]          actual,
  output logic                     out_vld,
  output logic [CHW-1:0]           out_ch,
  output logic [ERR_W-1:0]         pterm,
  output logic [I_W-I_SHIFT-1:0]   iterm,
  output logic [DD_W+4:0]          dterm
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_CLR  = 1'b1;

  localparam logic signed [IN_W:0]  ERR_HI = (IN_W+1)'(2**(ERR_W-1) - 1);
  localparam logic signed [IN_W:0]  ERR_LO = (IN_W+1)'(-(2**(ERR_W-1)));
  localparam logic signed [ERR_W:0] DD_HI  = (ERR_W+1)'(2**(DD_W-1) - 1);
  localparam logic signed [ERR_W:0] DD_LO  = (ERR_W+1)'(-(2**(DD_W-1)));
  localparam logic signed [I_W:0]   ACC_HI = (I_W+1)'(2**(I_W-1) - 1);
  localparam logic signed [I_W:0]   ACC_LO = (I_W+1)'(-(2**(I_W-1)));

  logic                     state_q, state_d;
  logic [CHW-1:0]           clr_idx_q, clr_idx_d;
  logic                     s1_vld_q, s1_vld_d;
  logic [CHW-1:0]           s1_ch_q, s1_ch_d;
  logic signed [ERR_W-1:0]  s1_err_q, s1_err_d;
  logic                     s2_vld_q, s2_vld_d;
  logic [CHW-1:0]           s2_ch_q, s2_ch_d;
  logic signed [ERR_W-1:0]  s2_p_q, s2_p_d;
  logic signed [DD_W-1:0]   s2_dd_q, s2_dd_d;
  logic [I_W-I_SHIFT-1:0]   s2_i_q, s2_i_d;
  logic                     out_vld_q, out_vld_d;
  logic [CHW-1:0]           out_ch_q, out_ch_d;
  logic [ERR_W-1:0]         pterm_q, pterm_d;
  logic [I_W-I_SHIFT-1:0]   iterm_q, iterm_d;
  logic [DD_W+4:0]          dterm_q, dterm_d;
  logic signed [ERR_W-1:0]  hist_q [NCH][D_DEPTH];
  logic signed [ERR_W-1:0]  hist_d [NCH][D_DEPTH];
  logic signed [I_W-1:0]    acc_q [NCH];
  logic signed [I_W-1:0]    acc_d [NCH];

  logic                     accept, ch_ok, commit;
  logic [CHW-1:0]           ch_idx;
  logic signed [IN_W:0]     err_full;
  logic signed [ERR_W-1:0]  err_sat;
  logic signed [ERR_W:0]    dd_full;
  logic signed [DD_W-1:0]   dd_sat;
  logic signed [I_W:0]      acc_sum;
  logic signed [I_W-1:0]    acc_sat;
  logic [DD_W+4:0]          dd_ext;

  always_comb begin
    in_rdy   = (state_q == ST_IDLE) && !clr;
    accept   = in_vld && in_rdy;
    err_full = {actual[IN_W-1], actual} - {desired[IN_W-1], desired};
    if (err_full > ERR_HI)      err_sat = ERR_HI[ERR_W-1:0];
    else if (err_full < ERR_LO) err_sat = ERR_LO[ERR_W-1:0];
    else                        err_sat = err_full[ERR_W-1:0];
    s1_vld_d = accept;
    s1_ch_d  = in_ch;
    s1_err_d = err_sat;

    // State is read and committed in the same stage, so back-to-back samples see it without forwarding.
    ch_ok   = 32'(s1_ch_q) < NCH;
    ch_idx  = ch_ok ? s1_ch_q : '0;
    commit  = s1_vld_q && ch_ok;
    dd_full = {s1_err_q[ERR_W-1], s1_err_q}
            - {hist_q[ch_idx][D_DEPTH-1][ERR_W-1], hist_q[ch_idx][D_DEPTH-1]};
    if (dd_full > DD_HI)      dd_sat = DD_HI[DD_W-1:0];
    else if (dd_full < DD_LO) dd_sat = DD_LO[DD_W-1:0];
    else                      dd_sat = dd_full[DD_W-1:0];
    acc_sum = {acc_q[ch_idx][I_W-1], acc_q[ch_idx]}
            + {{(I_W+1-ERR_W){s1_err_q[ERR_W-1]}}, s1_err_q};
    if (acc_sum > ACC_HI)      acc_sat = ACC_HI[I_W-1:0];
    else if (acc_sum < ACC_LO) acc_sat = ACC_LO[I_W-1:0];
    else                       acc_sat = acc_sum[I_W-1:0];

    hist_d = hist_q;
    acc_d  = acc_q;
    if (commit) begin
      hist_d[ch_idx][0] = s1_err_q;
      for (int i = 1; i < D_DEPTH; i++) hist_d[ch_idx][i] = hist_q[ch_idx][i-1];
      acc_d[ch_idx] = acc_sat;
    end

    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_IDLE) begin
      if (clr) begin
        state_d   = ST_CLR;
        clr_idx_d = '0;
      end
    end else begin
      for (int i = 0; i < D_DEPTH; i++) hist_d[clr_idx_q][i] = '0;
      acc_d[clr_idx_q] = '0;
      if (32'(clr_idx_q) == NCH - 1) state_d = ST_IDLE;
      else                           clr_idx_d = clr_idx_q + CHW'(1);
    end

    s2_vld_d = commit;
    s2_ch_d  = s1_ch_q;
    s2_p_d   = (s1_err_q >>> 1) + (s1_err_q >>> 3);
    s2_dd_d  = dd_sat;
    s2_i_d   = acc_sat[I_W-1:I_SHIFT];

    out_vld_d = s2_vld_q;
    out_ch_d  = out_ch_q;
    pterm_d   = pterm_q;
    iterm_d   = iterm_q;
    dterm_d   = dterm_q;
    dd_ext    = {{5{s2_dd_q[DD_W-1]}}, s2_dd_q};
    if (s2_vld_q) begin
      out_ch_d = s2_ch_q;
      pterm_d  = s2_p_q;
      iterm_d  = s2_i_q;
      dterm_d  = dd_ext * {{DD_W{D_COEFF[4]}}, D_COEFF};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_ch_q   <= '0;
      s1_err_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_ch_q   <= '0;
      s2_p_q    <= '0;
      s2_dd_q   <= '0;
      s2_i_q    <= '0;
      out_vld_q <= 1'b0;
      out_ch_q  <= '0;
      pterm_q   <= '0;
      iterm_q   <= '0;
      dterm_q   <= '0;
      hist_q    <= '{default: '0};
      acc_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      s1_vld_q  <= s1_vld_d;
      s1_ch_q   <= s1_ch_d;
      s1_err_q  <= s1_err_d;
      s2_vld_q  <= s2_vld_d;
      s2_ch_q   <= s2_ch_d;
      s2_p_q    <= s2_p_d;
      s2_dd_q   <= s2_dd_d;
      s2_i_q    <= s2_i_d;
      out_vld_q <= out_vld_d;
      out_ch_q  <= out_ch_d;
      pterm_q   <= pterm_d;
      iterm_q   <= iterm_d;
      dterm_q   <= dterm_d;
      hist_q    <= hist_d;
      acc_q     <= acc_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_ch  = out_ch_q;
  assign pterm   = pterm_q;
  assign iterm   = iterm_q;
  assign dterm   = dterm_q;

endmodule

// File: tb/tb_pid_math_mc.sv
// Randomized scoreboard bench for pid_math_mc against a plain-arithmetic PID model.
module tb_pid_math_mc;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, in_vld = 1'b0;
  logic [1:0] in_ch = '0;
  logic signed [15:0] desired = '0, actual = '0;
  logic in_rdy, out_vld;
  logic [1:0] out_ch;
  logic signed [9:0]  pterm;
  logic signed [11:0] iterm;
  logic signed [11:0] dterm;

  pid_math_mc dut (
    .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_rdy(in_rdy), .in_ch(in_ch),
    .desired(desired), .actual(actual), .out_vld(out_vld), .out_ch(out_ch),
    .pterm(pterm), .iterm(iterm), .dterm(dterm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int hq[3][$];
  int acc_m[3];
  int clr_cnt = 0;
  int e_ch[$], e_p[$], e_i[$], e_d[$], e_cyc[$];

  task automatic check(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int clamp(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      hq[c] = {};
      repeat (12) hq[c].push_back(0);
      acc_m[c] = 0;
    end
  endtask

  // One clock of stimulus; the model decides acceptance, and results are queued in issue order.
  task automatic drive(bit v, int ch, int des, int act, bit c);
    int e, dd, exp_rdy, oldest;
    in_vld = v; in_ch = 2'(ch); desired = 16'(des); actual = 16'(act); clr = c;
    #4;
    exp_rdy = (clr_cnt == 0 && !c) ? 1 : 0;
    check("in_rdy", int'(in_rdy), exp_rdy);
    if (v && exp_rdy == 1 && ch < 3) begin
      e = clamp(int'(actual) - int'(desired), -512, 511);
      oldest = hq[ch][11];
      dd = clamp(e - oldest, -64, 63);
      acc_m[ch] = clamp(acc_m[ch] + e, -32768, 32767);
      hq[ch].push_front(e);
      void'(hq[ch].pop_back());
      e_ch.push_back(ch);
      e_p.push_back((e >>> 1) + (e >>> 3));
      e_i.push_back(acc_m[ch] >>> 4);
      e_d.push_back(dd * 7);
      e_cyc.push_back(cyc + 3);
    end
    @(posedge clk); #1;
    if (clr_cnt > 0) clr_cnt--;
    else if (c) begin
      clr_cnt = 3;
      model_clear();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_vld) begin
        if (e_ch.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: out_vld=1 with nothing expected (cycle %0d)", cyc);
        end else begin
          check("out_latency", cyc, e_cyc.pop_front());
          check("out_ch", int'(out_ch), e_ch.pop_front());
          check("pterm", int'(pterm), e_p.pop_front());
          check("iterm", int'(iterm), e_i.pop_front());
          check("dterm", int'(dterm), e_d.pop_front());
        end
      end
    end
  end

  initial begin
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_pterm", int'(pterm), 0);
    check("rst_iterm", int'(iterm), 0);
    check("rst_dterm", int'(dterm), 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);

    drive(1, 0, 0, 100, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, -32768, 32767, 0);
    drive(1, 0, 32767, -32768, 0);
    repeat (13) drive(1, 1, 0, 40, 0);
    for (int k = 0; k < 24; k++) drive(1, (k % 2) ? 2 : 0, 0, (k % 2) ? -50 : 100, 0);
    drive(1, 3, 0, 300, 0);
    repeat (100) drive(1, 0, 0, 511, 0);
    drive(1, 0, 0, 77, 0);
    drive(1, 0, 0, 100, 1);
    repeat (3) drive(1, 0, 0, 100, 0);
    drive(1, 0, 0, 100, 0);
    drive(0, 0, 0, 0, 0);

    for (int k = 0; k < 400; k++) begin
      int ch, des, act;
      bit v, c;
      v = ($urandom_range(0, 3) != 0);
      ch = $urandom_range(0, 6) == 0 ? 3 : $urandom_range(0, 2);
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) begin
        des = int'($signed(16'($urandom)));
        act = int'($signed(16'($urandom)));
      end else begin
        des = $urandom_range(0, 400) - 200;
        act = $urandom_range(0, 400) - 200;
      end
      drive(v, ch, des, act, c);
    end

    in_vld = 1'b0; clr = 1'b0;
    for (int k = 0; k < 20 && e_ch.size() > 0; k++) @(posedge clk);
    @(negedge clk); #1;
    check("drain_pending", e_ch.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
